// File: rtl/axis_m_fft_out_pkg.sv
// Shared definitions for the FFT output-side AXI-Stream master: frame sizing
// helpers and the read-out FSM state type.
package axi_stream_pckg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LOAD,
    PUSH,
    DRAIN
  } fsm_state_t;

  // Beats carved out of one memory word (M_IF_BUFFER_SIZE).
  function automatic int m_if_buffer_size(input int vlw_wdt, input int tdata_wdt);
    return vlw_wdt / tdata_wdt;
  endfunction

  // Beats in one frame (M_PACKET_CNT).
  function automatic int m_packet_cnt(input int fft_size_log2, input int vlw_wdt,
                                      input int tdata_wdt);
    return (2 ** fft_size_log2) * (vlw_wdt / tdata_wdt);
  endfunction

  // Master FIFO pointer index width (M_FIFO_ADDR_WDT).
  function automatic int m_fifo_addr_wdt(input int fifo_size);
    return $clog2(fifo_size);
  endfunction

endpackage

// File: rtl/axis_m_fft_out_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module axis_m_fifo
  import axi_stream_pckg::*;
#(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = m_fifo_addr_wdt(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axis_m_fft_out.sv
// FFT result read-out: reads every memory word of a frame, slices it MSB-first
// into AXI-Stream beats through a FWFT FIFO, and flags the last beat with TLAST.
module axis_m_fft_out
  import axi_stream_pckg::*;
#(
  parameter int VLW_WDT           = 64,
  parameter int M_TDATA_WDT       = 32,
  parameter int M_FIFO_SIZE       = 16,
  parameter int C_FFT_SIZE_LOG2   = 12,
  parameter int OUTPUT_MEM_OFFSET = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       mem_rd_en_o,
  output logic [C_FFT_SIZE_LOG2-1:0] mem_rd_addr_o,
  input  logic [VLW_WDT-1:0]         mem_rd_data_i,
  output logic [M_TDATA_WDT-1:0]     m_axis_tdata_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic                       m_axis_tlast_o
);

  localparam int BUF_SIZE = m_if_buffer_size(VLW_WDT, M_TDATA_WDT);
  localparam int SLICE_W  = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam int FIFO_W   = M_TDATA_WDT + 1;

  localparam logic [C_FFT_SIZE_LOG2:0]   FRAME_WORDS = {1'b1, {C_FFT_SIZE_LOG2{1'b0}}};
  localparam logic [C_FFT_SIZE_LOG2-1:0] ADDR_BASE   = C_FFT_SIZE_LOG2'(OUTPUT_MEM_OFFSET);
  localparam logic [SLICE_W-1:0]         SLICE_LAST  = SLICE_W'(BUF_SIZE - 1);

  fsm_state_t state, state_nxt;

  // word_cnt counts words already requested, so it reaches FRAME_WORDS
  // exactly when the word being sliced is the last one of the frame.
  logic [C_FFT_SIZE_LOG2:0] word_cnt;
  logic [SLICE_W-1:0]       slice_idx;
  logic [VLW_WDT-1:0]       word_p1;
  logic [M_TDATA_WDT-1:0]   slice_data;
  logic [FIFO_W-1:0]        fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     rd_en;
  logic                     done;
  logic                     slice_last;
  logic                     last_word;

  assign slice_last = (slice_idx == SLICE_LAST);
  assign last_word  = (word_cnt == FRAME_WORDS);

  always_comb begin
    slice_data = '0;
    for (int k = 0; k < BUF_SIZE; k++) begin
      if (slice_idx == SLICE_W'(k))
        slice_data = word_p1[VLW_WDT-1-k*M_TDATA_WDT -: M_TDATA_WDT];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    push      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start_i) state_nxt = RD;
      RD: begin
        rd_en     = 1'b1;
        state_nxt = LOAD;
      end
      LOAD:  state_nxt = PUSH;
      PUSH: begin
        if (!fifo_full) begin
          push = 1'b1;
          if (slice_last) begin
            if (!last_word) begin
              rd_en     = 1'b1;
              state_nxt = LOAD;
            end else begin
              state_nxt = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt  <= '0;
      slice_idx <= '0;
    end else begin
      if (rd_en)     word_cnt <= word_cnt + 1'b1;
      else if (done) word_cnt <= '0;
      if (push) slice_idx <= slice_last ? '0 : slice_idx + 1'b1;
    end
  end

  // Word buffer stage: memory data is valid in LOAD, one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (state == LOAD) word_p1 <= mem_rd_data_i;
  end

  assign pop = ~fifo_empty & m_axis_tready_i;

  axis_m_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (M_FIFO_SIZE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({slice_last & last_word, slice_data}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign busy_o          = (state != IDLE);
  assign done_o          = done;
  assign mem_rd_en_o     = rd_en;
  assign mem_rd_addr_o   = ADDR_BASE + word_cnt[C_FFT_SIZE_LOG2-1:0];
  assign m_axis_tvalid_o = ~fifo_empty;
  // Mask the head when empty so stale or uninitialised storage never shows.
  assign {m_axis_tlast_o, m_axis_tdata_o} = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_axis_m_fft_out.sv
// Self-checking bench for axis_m_fft_out with randomized TREADY and a
// frame-level reference model of the expected beat stream.
module tb_axis_m_fft_out;
  import axi_stream_pckg::*;

  localparam int VLW  = 64;
  localparam int TW   = 32;
  localparam int FS   = 16;
  localparam int LOG2 = 12;
  localparam int BUF  = VLW / TW;
  localparam int NB   = m_packet_cnt(LOG2, VLW, TW);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [LOG2-1:0] rd_addr;
  logic [VLW-1:0]  rd_data;
  logic [TW-1:0]   tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  int vectors     = 0;
  int miscompares = 0;

  logic            s_v, s_l, s_done, s_busy, s_rden;
  logic [TW-1:0]   s_d;
  logic [LOG2-1:0] s_addr;

  always #5 clk = ~clk;

  axis_m_fft_out dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .busy_o          (busy),
    .done_o          (done),
    .mem_rd_en_o     (rd_en),
    .mem_rd_addr_o   (rd_addr),
    .mem_rd_data_i   (rd_data),
    .m_axis_tdata_o  (tdata),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .m_axis_tlast_o  (tlast)
  );

  function automatic logic [VLW-1:0] mem_word(input int w);
    return {32'(w), ~32'(w)};
  endfunction

  // Reference: beat k is slice (k mod BUF) of word (k / BUF), MSB slice first.
  function automatic logic [TW-1:0] exp_data(input int k);
    logic [VLW-1:0] wv;
    wv = mem_word(k / BUF);
    return TW'(wv >> ((BUF - 1 - (k % BUF)) * TW));
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem_word(int'(rd_addr));

  // Sample outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic cyc(input bit rdy, input bit st);
    @(negedge clk);
    s_v = tvalid; s_d = tdata; s_l = tlast;
    s_done = done; s_busy = busy; s_rden = rd_en; s_addr = rd_addr;
    tready = rdy;
    start  = st;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tready = 1'b0;
    repeat (3) cyc(0, 0);
    vectors++; if (s_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", s_busy); end
    vectors++; if (s_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", s_done); end
    vectors++; if (s_rden !== 1'b0) begin miscompares++; $display("FAIL reset_rden got %b exp 0", s_rden); end
    vectors++; if (s_v !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got %b exp 0", s_v); end
    vectors++; if (s_l !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got %b exp 0", s_l); end
    vectors++; if (s_addr !== '0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", s_addr); end
    vectors++; if (s_d !== '0) begin miscompares++; $display("FAIL reset_tdata got %h exp 0", s_d); end
    rst = 1'b0;
    repeat (3) cyc(0, 0);
    vectors++; if (s_busy !== 1'b0 || s_v !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset busy %b tvalid %b exp 0 0", s_busy, s_v);
    end
  endtask

  task automatic test_full_frame();
    int beat = 0, n = 0, first_v = -1, last_at = -1, done_at = -1, lasts = 0;
    cyc(1, 1);
    while (done_at < 0 && n < 20000) begin
      cyc(1, 0); n++;
      if (n == 1) begin
        vectors++;
        if (s_rden !== 1'b1 || s_addr !== '0) begin
          miscompares++; $display("FAIL start_read rden %b addr %h exp 1 0", s_rden, s_addr);
        end
      end
      if (s_v === 1'b1 && first_v < 0) begin
        first_v = n;
        vectors++;
        if (n != 4 || s_d !== exp_data(0)) begin
          miscompares++; $display("FAIL first_tvalid cycle %0d data %h exp 4 %h", n, s_d, exp_data(0));
        end
      end
      if (s_v === 1'b1) begin
        vectors++;
        if (s_d !== exp_data(beat) || s_l !== (beat == NB - 1)) begin
          miscompares++; $display("FAIL full_beat %0d got %h/%b exp %h/%b", beat, s_d, s_l, exp_data(beat), beat == NB - 1);
        end
        if (s_l === 1'b1) begin lasts++; last_at = n; end
        beat++;
      end
      if (s_done === 1'b1) done_at = n;
    end
    vectors++; if (beat != NB || lasts != 1) begin miscompares++; $display("FAIL full_count beats %0d tlasts %0d exp %0d 1", beat, lasts, NB); end
    vectors++; if (done_at < 0 || done_at != last_at + 1) begin miscompares++; $display("FAIL full_done at %0d exp %0d", done_at, last_at + 1); end
    cyc(1, 0);
    vectors++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin miscompares++; $display("FAIL full_idle busy %b done %b exp 0 0", s_busy, s_done); end
  endtask

  task automatic test_backpressure();
    int beat = 0, n = 0, rd_cnt = 0, last_at = -1, done_at = -1;
    cyc(0, 1);
    for (int i = 1; i <= 100; i++) begin
      cyc(0, 0);
      if (s_rden === 1'b1) rd_cnt++;
      if (i >= 4) begin
        vectors++;
        if (s_v !== 1'b1 || s_d !== exp_data(0) || s_l !== 1'b0) begin
          miscompares++; $display("FAIL hold_beat0 cycle %0d got %b/%h exp 1/%h", i, s_v, s_d, exp_data(0));
        end
      end
      if (i >= 60) begin
        vectors++;
        if (s_rden !== 1'b0) begin miscompares++; $display("FAIL hold_no_read cycle %0d got %b exp 0", i, s_rden); end
      end
    end
    // 16 FIFO entries hold 8 words, plus one more word waiting in the buffer.
    vectors++; if (rd_cnt != FS / BUF + 1) begin miscompares++; $display("FAIL hold_reads got %0d exp %0d", rd_cnt, FS / BUF + 1); end
    while (done_at < 0 && n < 20000) begin
      cyc(1, 0); n++;
      if (s_v === 1'b1) begin
        vectors++;
        if (s_d !== exp_data(beat) || s_l !== (beat == NB - 1)) begin
          miscompares++; $display("FAIL bp_beat %0d got %h/%b exp %h/%b", beat, s_d, s_l, exp_data(beat), beat == NB - 1);
        end
        if (s_l === 1'b1) last_at = n;
        beat++;
      end
      if (s_done === 1'b1) done_at = n;
    end
    vectors++; if (beat != NB) begin miscompares++; $display("FAIL bp_count got %0d exp %0d", beat, NB); end
    vectors++; if (done_at < 0 || done_at != last_at + 1) begin miscompares++; $display("FAIL bp_done at %0d exp %0d", done_at, last_at + 1); end
  endtask

  task automatic test_random_ready(input int pct, input bit poke);
    int beat = 0, n = 0, lasts = 0, last_at = -1, done_at = -1;
    bit rdy, st, poked = 1'b0, prev_v = 1'b0, prev_rdy = 1'b0;
    logic [TW-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    cyc(0, 1);
    while (done_at < 0 && n < 40000) begin
      rdy = ($urandom_range(1, 100) <= pct);
      st  = poke && !poked && beat == 500;
      if (st) poked = 1'b1;
      cyc(rdy, st); n++;
      if (prev_v && !prev_rdy) begin
        vectors++;
        if (s_v !== 1'b1 || s_d !== prev_d || s_l !== prev_l) begin
          miscompares++; $display("FAIL axis_stable cycle %0d got %b/%h exp 1/%h", n, s_v, s_d, prev_d);
        end
      end
      if (s_v === 1'b1 && rdy) begin
        vectors++;
        if (s_d !== exp_data(beat) || s_l !== (beat == NB - 1)) begin
          miscompares++; $display("FAIL rand_beat %0d got %h/%b exp %h/%b", beat, s_d, s_l, exp_data(beat), beat == NB - 1);
        end
        if (s_l === 1'b1) begin lasts++; last_at = n; end
        beat++;
      end
      if (s_done === 1'b1) done_at = n;
      prev_v = (s_v === 1'b1); prev_rdy = rdy; prev_d = s_d; prev_l = s_l;
    end
    vectors++; if (beat != NB || lasts != 1) begin miscompares++; $display("FAIL rand_count beats %0d tlasts %0d exp %0d 1", beat, lasts, NB); end
    vectors++; if (done_at < 0 || done_at != last_at + 1) begin miscompares++; $display("FAIL rand_done at %0d exp %0d", done_at, last_at + 1); end
  endtask

  task automatic test_reset_midframe();
    int beat = 0, n = 0, first_v = -1;
    cyc(1, 1);
    while (beat < 3000 && n < 10000) begin
      cyc(1, 0); n++;
      if (s_v === 1'b1) begin
        vectors++;
        if (s_d !== exp_data(beat)) begin miscompares++; $display("FAIL pre_rst_beat %0d got %h exp %h", beat, s_d, exp_data(beat)); end
        beat++;
      end
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
      miscompares++; $display("FAIL async_reset tvalid %b busy %b rden %b exp 0 0 0", tvalid, busy, rd_en);
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    cyc(1, 1);
    beat = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1, 0);
      if (i == 1) begin
        vectors++;
        if (s_rden !== 1'b1 || s_addr !== '0) begin miscompares++; $display("FAIL restart_read rden %b addr %h exp 1 0", s_rden, s_addr); end
      end
      if (s_v === 1'b1) begin
        if (first_v < 0) begin
          first_v = i;
          vectors++; if (i != 4) begin miscompares++; $display("FAIL restart_first_tvalid cycle %0d exp 4", i); end
        end
        vectors++;
        if (s_d !== exp_data(beat)) begin miscompares++; $display("FAIL restart_beat %0d got %h exp %h", beat, s_d, exp_data(beat)); end
        beat++;
      end
    end
    vectors++; if (first_v < 0) begin miscompares++; $display("FAIL restart_no_tvalid got none exp cycle 4"); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_random_ready(50, 1'b1);
    test_random_ready(75, 1'b0);
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_m_fft_out.md
# axis_m_fft_out

Streaming read-out engine on the FFT output side: on a start pulse it reads every VLW_WDT-bit word of the FFT result memory and serializes each word into M_TDATA_WDT-bit AXI4-Stream beats. It buffers the beats in a small FIFO and marks the final beat of the frame with TLAST. It is the transmitting counterpart of the AXI-Stream slave input path that loads samples into the same memory, and it sits between the FFT memory read port and the DMA/PS interface.

## Interface
Parameters:
- VLW_WDT, 64: memory word width, {re, im} halves.
- M_TDATA_WDT, 32: AXIS beat width. VLW_WDT must be an integer multiple of it.
- M_FIFO_SIZE, 16: output FIFO depth in beats. Power of two.
- C_FFT_SIZE_LOG2, 12: memory address width. One frame is 2**C_FFT_SIZE_LOG2 words.
- OUTPUT_MEM_OFFSET, 0: first word address of the frame.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle frame start request.
- busy_o  out  1  high while a frame is in progress.
- done_o  out  1  one-cycle pulse at frame end.
- mem_rd_en_o  out  1  memory read strobe.
- mem_rd_addr_o  out  C_FFT_SIZE_LOG2  memory read address.
- mem_rd_data_i  in  VLW_WDT  read data, valid 1 cycle after the strobe.
- m_axis_tdata_o  out  M_TDATA_WDT  stream data.
- m_axis_tvalid_o  out  1  stream valid.
- m_axis_tready_i  in  1  stream ready.
- m_axis_tlast_o  out  1  last beat of the frame.

## Operation
- Frame: words 0..2**C_FFT_SIZE_LOG2-1. Word i is read at address (OUTPUT_MEM_OFFSET + i) mod 2**C_FFT_SIZE_LOG2.
- Beat order within a word: most significant slice first. For the defaults, beat 0 = [63:32] (re) and beat 1 = [31:0] (im).
- Beats per frame: M_PACKET_CNT = 2**C_FFT_SIZE_LOG2 * VLW_WDT/M_TDATA_WDT (8192 for the defaults). TLAST is set only on beat M_PACKET_CNT-1.
- FSM states:
  - IDLE: on start_i, go to RD.
  - RD: assert mem_rd_en_o, go to LOAD.
  - LOAD: capture mem_rd_data_i into the word buffer, go to PUSH.
  - PUSH: write one slice into the FIFO per cycle while the FIFO is not full. On the final slice of a word: if words remain, assert mem_rd_en_o for the next address in that same cycle and go to LOAD; otherwise go to DRAIN.
  - DRAIN: wait until the FIFO is empty, then pulse done_o and go to IDLE.
- FIFO entries are {tlast, tdata}, first-word fall-through. m_axis_tvalid_o = !empty, and tdata/tlast come from the FIFO head.
- Pop on tvalid & tready.
- Push is allowed only when not full, even if a pop happens in the same cycle. While blocked, the slice index holds and no memory read is issued.
- start_i is ignored outside IDLE.
- busy_o is high in every state except IDLE.
- Once tvalid is high it stays high, with tdata/tlast stable, until the handshake occurs (AXIS rule).

## Timing
- Reset values: busy_o, done_o, mem_rd_en_o, m_axis_tvalid_o and m_axis_tlast_o = 0; mem_rd_addr_o = OUTPUT_MEM_OFFSET; m_axis_tdata_o = 0. FIFO is empty, FSM is in IDLE, counters are 0.
- Start latency: start_i in cycle T → mem_rd_en_o in T+1 → capture in T+2 → first push in T+3 → tvalid in T+4.
- Steady state with no backpressure: 2 beats per 3 cycles (LOAD, PUSH, PUSH).
- done_o: fires in the cycle after the TLAST handshake, since the FIFO is empty at that point.
- FIFO pointers are C_FIFO_ADDR_WDT+1 bits wide. Full when the MSBs differ and the rest are equal; empty when all bits are equal. Pointers wrap modulo 2*M_FIFO_SIZE.
- Word counter: C_FFT_SIZE_LOG2+1 bits, so the terminal count is detected without overflow.
- Address: C_FFT_SIZE_LOG2 bits, wraps naturally.
- Reset asserted mid-frame: all state is cleared asynchronously, buffered beats are discarded, and tvalid drops immediately. The next start begins again at word 0.

## Structure
- Shared package (axi_stream_pckg) holds:
  - M_PACKET_CNT and M_IF_BUFFER_SIZE = VLW_WDT/M_TDATA_WDT.
  - M_FIFO_ADDR_WDT = $clog2(M_FIFO_SIZE), derived from the master FIFO size.
  - The FSM state enum typedef (IDLE, RD, LOAD, PUSH, DRAIN).
- Sub-module axis_m_fifo: generic synchronous first-word-fall-through FIFO, width M_TDATA_WDT+1, depth M_FIFO_SIZE, with full/empty flags.

## Test plan
- Full frame with tready tied to 1, mem[i] = {i, ~i} → 8192 beats; beat 2i = i and beat 2i+1 = ~i (32-bit); tlast only on beat 8191; done_o one cycle after it; busy_o low afterwards.
- tready held 0 for 100 cycles after start → FIFO holds 16 entries; tvalid stays 1 with beat 0 stable; mem_rd_en_o stays 0; afterwards the full sequence arrives with no loss or duplication.
- Random tready at 50% → beat sequence identical to the first scenario; no tvalid drop before a handshake; exactly one tlast.
- start_i pulsed again at beat 500 → ignored, frame unchanged. A start after done_o → identical second frame.
- rst asserted at beat 3000 → tvalid, busy_o and mem_rd_en_o are 0 immediately. A new start → mem_rd_addr_o = 0 at T+1 and first tvalid at T+4.
- Start at cycle 0 → mem_rd_en_o at cycle 1 with addr 0, and m_axis_tvalid_o first high at cycle 4 with tdata = mem[0][63:32].
